ps2_key_fifo: RTL and testbench

- Keyboard event buffer that sits directly upstream of the system block's memory-mapped ps2_key port.
- Converts the toggle-flagged ps2_key bus from the HPS framework into a queue of key events that the Z80 can read.
- The CPU pops events at its own pace, so presses arriving between polls are no longer lost.
- The system block maps two bytes, status and head entry, in place of the raw ps2_key bytes.

---
 rtl/ps2_key_fifo_pkg.sv | 31 +++
 rtl/ps2_key_fifo_if.sv | 26 ++
 rtl/ps2_key_fifo_mem.sv | 63 ++++++
 rtl/ps2_key_fifo.sv | 97 +++++++++
 tb/tb_ps2_key_fifo.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_fifo_pkg.sv
// Shared definitions for the PS/2 key event buffer: raw bus bit positions,
// queue entry layout and status byte layout.
package ps2_key_pkg;

   // Raw toggle-flagged bus from the HPS framework
   localparam int KEY_W       = 11;
   localparam int KEY_TOG     = 10;
   localparam int KEY_PRESSED = 9;
   localparam int KEY_EXT     = 8;

   // Queue entry layout
   localparam int ENTRY_W      = 10;
   localparam int ENT_CODE_LSB = 0;
   localparam int ENT_CODE_MSB = 7;
   localparam int ENT_PRESSED  = 8;
   localparam int ENT_EXTENDED = 9;

   // Status byte layout
   localparam int ST_EMPTY   = 7;
   localparam int ST_FULL    = 6;
   localparam int ST_OVF     = 5;
   localparam int ST_CNT_MSB = 4;
   localparam int ST_CNT_LSB = 0;

   typedef struct packed {
      logic       extended;
      logic       pressed;
      logic [7:0] code;
   } key_entry_t;

endpackage

// File: rtl/ps2_key_fifo_if.sv
// CPU/HPS-facing signal bundle of the key event buffer.
interface ps2_key_fifo_if
   import ps2_key_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
);
   logic [KEY_W-1:0]    ps2_key;
   logic                pop;
   logic                clr_ovf;
   logic [7:0]          head_code;
   logic [1:0]          head_flags;
   logic [7:0]          status;
   logic [DEPTH_LOG2:0] count;

   // Producer / CPU side
   modport master (
      output ps2_key, pop, clr_ovf,
      input  head_code, head_flags, status, count
   );

   // Buffer side
   modport slave (
      input  ps2_key, pop, clr_ovf,
      output head_code, head_flags, status, count
   );
endinterface

// File: rtl/ps2_key_fifo_mem.sv
// Register-array FIFO holding key entries, with push/pop/count bookkeeping.
// A push into a full FIFO is accepted only if a pop happens on the same clock.
module key_fifo_mem
   import ps2_key_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic [ENTRY_W-1:0]  wdata,
   output logic [ENTRY_W-1:0]  rdata,
   output logic [DEPTH_LOG2:0] count,
   output logic                empty,
   output logic                full,
   output logic                drop
);
   localparam int                  DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [ENTRY_W-1:0]    mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic                  do_push;
   logic                  do_pop;

   // Decide which requests take effect this clock
   always_comb begin
      empty   = (count == '0);
      full    = (count == DEPTH_CNT);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      drop    = push && full && !do_pop;
   end

   // Pointer and occupancy state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];

endmodule

// File: rtl/ps2_key_fifo.sv
// Keyboard event buffer: turns the toggle-flagged ps2_key bus into a queue
// of key events that the CPU pops one per read strobe.
module ps2_key_fifo
   import ps2_key_pkg::*;
#(
   parameter int DEPTH_LOG2   = 4,
   parameter bit DROP_RELEASE = 1'b0
) (
   input  logic          clk_24,
   input  logic          reset,
   ps2_key_fifo_if.slave bus
);
   logic                tog_q;
   logic                armed;
   logic                pop_q;
   logic                key_event;
   logic                push;
   logic                pop_edge;
   key_entry_t          entry;
   logic [ENTRY_W-1:0]  rdata;
   logic [ENTRY_W-1:0]  head_q;
   logic [DEPTH_LOG2:0] count;
   logic                empty;
   logic                full;
   logic                drop;
   logic                overflow;

   // The status byte only has five count bits
   function automatic logic [4:0] sat_cnt5(input logic [DEPTH_LOG2:0] c);
      if (int'(c) > 31) return 5'd31;
      return 5'(c);
   endfunction

   // Edge detectors; armed keeps a stale toggle level from making a phantom event
   always_ff @(posedge clk_24 or posedge reset) begin
      if (reset) begin
         tog_q <= 1'b0;
         pop_q <= 1'b0;
         armed <= 1'b0;
      end else begin
         tog_q <= bus.ps2_key[KEY_TOG];
         pop_q <= bus.pop;
         armed <= 1'b1;
      end
   end

   // Event qualification and entry packing
   always_comb begin
      key_event      = armed && (bus.ps2_key[KEY_TOG] != tog_q);
      push           = key_event && !(DROP_RELEASE && !bus.ps2_key[KEY_PRESSED]);
      pop_edge       = bus.pop && !pop_q;
      entry.extended = bus.ps2_key[KEY_EXT];
      entry.pressed  = bus.ps2_key[KEY_PRESSED];
      entry.code     = bus.ps2_key[7:0];
   end

   key_fifo_mem #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem (
      .clk   (clk_24),
      .rst   (reset),
      .push  (push),
      .pop   (pop_edge),
      .wdata (entry),
      .rdata (rdata),
      .count (count),
      .empty (empty),
      .full  (full),
      .drop  (drop)
   );

   // Sticky overflow; a dropping push beats a simultaneous clear
   always_ff @(posedge clk_24 or posedge reset) begin
      if (reset)             overflow <= 1'b0;
      else if (drop)         overflow <= 1'b1;
      else if (bus.clr_ovf)  overflow <= 1'b0;
   end

   // Head register lags the queue by one clock so a strobe sees the pre-pop entry
   always_ff @(posedge clk_24 or posedge reset) begin
      if (reset)      head_q <= '0;
      else if (empty) head_q <= '0;
      else            head_q <= rdata;
   end

   // Output packing
   always_comb begin
      bus.head_code                      = head_q[ENT_CODE_MSB:ENT_CODE_LSB];
      bus.head_flags                     = {head_q[ENT_EXTENDED], head_q[ENT_PRESSED]};
      bus.count                          = count;
      bus.status[ST_EMPTY]               = empty;
      bus.status[ST_FULL]                = full;
      bus.status[ST_OVF]                 = overflow;
      bus.status[ST_CNT_MSB:ST_CNT_LSB]  = sat_cnt5(count);
   end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Bench for the key event buffer: directed scenarios plus a randomized run,
// checked against a queue-based model of the event buffer behaviour.
module tb_ps2_key_fifo;
   localparam int DL2   = 4;
   localparam int DEPTH = 16;

   logic        clk_24 = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic        pop;
   logic        clr_ovf;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [9:0] q[$];
   bit         m_ovf, m_armed, m_tog, m_pop;
   logic [9:0] m_head;

   always #5 clk_24 = ~clk_24;

   ps2_key_fifo_if #(.DEPTH_LOG2(DL2)) ifa ();
   ps2_key_fifo_if #(.DEPTH_LOG2(DL2)) ifb ();

   assign ifa.ps2_key = ps2_key;
   assign ifa.pop     = pop;
   assign ifa.clr_ovf = clr_ovf;
   assign ifb.ps2_key = ps2_key;
   assign ifb.pop     = pop;
   assign ifb.clr_ovf = clr_ovf;

   ps2_key_fifo #(.DEPTH_LOG2(DL2), .DROP_RELEASE(1'b0)) dut_a (
      .clk_24 (clk_24),
      .reset  (reset),
      .bus    (ifa.slave)
   );

   ps2_key_fifo #(.DEPTH_LOG2(DL2), .DROP_RELEASE(1'b1)) dut_b (
      .clk_24 (clk_24),
      .reset  (reset),
      .bus    (ifb.slave)
   );

   // Advance one clock, updating the model from the inputs seen at that edge
   task automatic tick();
      bit         evt, pe;
      logic [9:0] e;
      if (reset) begin
         q.delete();
         m_ovf = 0; m_armed = 0; m_tog = 0; m_pop = 0; m_head = '0;
      end else begin
         m_head = (q.size() > 0) ? q[0] : 10'd0;
         evt = m_armed && (ps2_key[10] != m_tog);
         pe  = pop && !m_pop;
         e   = {ps2_key[8], ps2_key[9], ps2_key[7:0]};
         if (clr_ovf) m_ovf = 0;
         if (pe && q.size() > 0) void'(q.pop_front());
         if (evt) begin
            if (q.size() < DEPTH) q.push_back(e);
            else                  m_ovf = 1;
         end
         m_tog = ps2_key[10]; m_pop = pop; m_armed = 1;
      end
      @(posedge clk_24); #1;
   endtask

   task automatic press(input logic [7:0] code, input logic p, input logic x);
      ps2_key = {~ps2_key[10], p, x, code};
   endtask

   task automatic pop_strobe(input int hold);
      pop = 1'b1;
      repeat (hold) tick();
      pop = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; ps2_key = 11'h400; pop = 1'b0; clr_ovf = 1'b0;
      #3;
      n_cmp++;
      if ({ifa.count, ifa.status, ifa.head_code, ifa.head_flags} !== {5'd0, 8'h80, 8'h00, 2'b00}) begin
         n_bad++;
         $display("FAIL reset_values: got cnt=%0d st=%h head=%h/%b want cnt=0 st=80 head=00/00",
                  ifa.count, ifa.status, ifa.head_code, ifa.head_flags);
      end
      tick();
      reset = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if (ifa.count !== 5'd0 || ifa.status !== 8'h80) begin
         n_bad++;
         $display("FAIL reset_release_no_push: got cnt=%0d st=%h want cnt=0 st=80", ifa.count, ifa.status);
      end
   endtask

   task automatic test_basic();
      press(8'h1C, 1'b1, 1'b0); tick();
      n_cmp++;
      if (ifa.count !== 5'd1 || ifa.head_code !== 8'h00) begin
         n_bad++;
         $display("FAIL push_head_lag: got cnt=%0d head=%h want cnt=1 head=00", ifa.count, ifa.head_code);
      end
      tick();
      n_cmp++;
      if (ifa.head_code !== 8'h1C || ifa.head_flags !== 2'b01) begin
         n_bad++;
         $display("FAIL first_head: got %h/%b want 1c/01", ifa.head_code, ifa.head_flags);
      end
      press(8'h32, 1'b1, 1'b1); tick();
      press(8'h21, 1'b1, 1'b0); tick();
      tick();
      n_cmp++;
      if (ifa.count !== 5'd3 || ifa.head_code !== 8'h1C) begin
         n_bad++;
         $display("FAIL three_pushed: got cnt=%0d head=%h want cnt=3 head=1c", ifa.count, ifa.head_code);
      end
      pop = 1'b1; tick();
      n_cmp++;
      if (ifa.count !== 5'd2 || ifa.head_code !== 8'h1C) begin
         n_bad++;
         $display("FAIL pop_pre_value: got cnt=%0d head=%h want cnt=2 head=1c", ifa.count, ifa.head_code);
      end
      repeat (5) tick();
      pop = 1'b0; tick();
      n_cmp++;
      if (ifa.count !== 5'd2 || ifa.head_code !== 8'h32 || ifa.head_flags !== 2'b11) begin
         n_bad++;
         $display("FAIL pop1_head: got cnt=%0d head=%h/%b want cnt=2 head=32/11", ifa.count, ifa.head_code, ifa.head_flags);
      end
      pop_strobe(6);
      n_cmp++;
      if (ifa.count !== 5'd1 || ifa.head_code !== 8'h21) begin
         n_bad++;
         $display("FAIL pop2_head: got cnt=%0d head=%h want cnt=1 head=21", ifa.count, ifa.head_code);
      end
      pop_strobe(6);
      n_cmp++;
      if (ifa.count !== 5'd0 || ifa.status !== 8'h80 || ifa.head_code !== 8'h00) begin
         n_bad++;
         $display("FAIL pop3_empty: got cnt=%0d st=%h head=%h want cnt=0 st=80 head=00", ifa.count, ifa.status, ifa.head_code);
      end
      pop_strobe(3);
      n_cmp++;
      if (ifa.count !== 5'd0 || ifa.status !== 8'h80) begin
         n_bad++;
         $display("FAIL pop_underflow: got cnt=%0d st=%h want cnt=0 st=80", ifa.count, ifa.status);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         press(8'(i), 1'($urandom), 1'($urandom));
         tick();
      end
      tick();
      n_cmp++;
      if (ifa.count !== 5'd16 || ifa.status !== 8'h70) begin
         n_bad++;
         $display("FAIL overflow_status: got cnt=%0d st=%h want cnt=16 st=70", ifa.count, ifa.status);
      end
      for (int i = 1; i <= 16; i++) begin
         n_cmp++;
         if (ifa.head_code !== 8'(i) || {ifa.head_flags[1], ifa.head_flags[0]} !== {q[0][9], q[0][8]}) begin
            n_bad++;
            $display("FAIL overflow_order: got %h/%b want %h/%b", ifa.head_code, ifa.head_flags, 8'(i), q[0][9:8]);
         end
         pop_strobe($urandom_range(1, 4));
      end
      n_cmp++;
      if (ifa.count !== 5'd0 || ifa.status !== 8'hA0) begin
         n_bad++;
         $display("FAIL overflow_drained: got cnt=%0d st=%h want cnt=0 st=a0", ifa.count, ifa.status);
      end
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      n_cmp++;
      if (ifa.status !== 8'h80) begin
         n_bad++;
         $display("FAIL clr_ovf: got st=%h want st=80", ifa.status);
      end
   endtask

   task automatic test_full_pop_push();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         press(8'($urandom_range(0, 127)), 1'b1, 1'($urandom));
         tick();
      end
      tick();
      press(8'hAA, 1'b1, 1'b0);
      pop = 1'b1; tick();
      pop = 1'b0; tick();
      n_cmp++;
      if (ifa.count !== 5'd16 || ifa.status !== 8'h50) begin
         n_bad++;
         $display("FAIL full_push_pop: got cnt=%0d st=%h want cnt=16 st=50", ifa.count, ifa.status);
      end
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if ({ifa.head_flags, ifa.head_code} !== {q[0][9:8], q[0][7:0]} || (i == 15 && ifa.head_code !== 8'hAA)) begin
            n_bad++;
            $display("FAIL full_drain[%0d]: got %h/%b want %h/%b", i, ifa.head_code, ifa.head_flags, q[0][7:0], q[0][9:8]);
         end
         pop_strobe($urandom_range(1, 3));
      end
   endtask

   task automatic test_drop_release();
      do_reset();
      press(8'h1C, 1'b1, 1'b0); tick();
      press(8'h1C, 1'b0, 1'b0); tick();
      tick();
      n_cmp++;
      if (ifb.count !== 5'd1 || ifb.head_code !== 8'h1C || ifb.head_flags !== 2'b01) begin
         n_bad++;
         $display("FAIL drop_release: got cnt=%0d head=%h/%b want cnt=1 head=1c/01", ifb.count, ifb.head_code, ifb.head_flags);
      end
      n_cmp++;
      if (ifa.count !== 5'(q.size())) begin
         n_bad++;
         $display("FAIL keep_release: got cnt=%0d want cnt=%0d", ifa.count, q.size());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         press(8'($urandom), 1'b1, 1'b0);
         tick();
      end
      n_cmp++;
      if (ifa.count !== 5'd5) begin
         n_bad++;
         $display("FAIL mid_fill: got cnt=%0d want cnt=5", ifa.count);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (ifa.count !== 5'd0 || ifa.status !== 8'h80 || ifa.head_code !== 8'h00) begin
         n_bad++;
         $display("FAIL async_reset: got cnt=%0d st=%h head=%h want cnt=0 st=80 head=00", ifa.count, ifa.status, ifa.head_code);
      end
      tick();
      reset = 1'b0;
      press(8'h77, 1'b1, 1'b0); tick();
      n_cmp++;
      if (ifa.count !== 5'd0) begin
         n_bad++;
         $display("FAIL arm_phantom: got cnt=%0d want cnt=0", ifa.count);
      end
      press(8'h5A, 1'b1, 1'b1); tick();
      tick();
      n_cmp++;
      if (ifa.count !== 5'd1 || ifa.head_code !== 8'h5A || ifa.head_flags !== 2'b11) begin
         n_bad++;
         $display("FAIL rearmed_push: got cnt=%0d head=%h/%b want cnt=1 head=5a/11", ifa.count, ifa.head_code, ifa.head_flags);
      end
   endtask

   task automatic test_random();
      logic [7:0] e_st;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, (c < 200) ? 2 : 5) == 0)
            press(8'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, (c < 200) ? 5 : 1) == 0) pop = ~pop;
         clr_ovf = ($urandom_range(0, 19) == 0);
         tick();
         e_st = {q.size() == 0, q.size() == DEPTH, m_ovf, 5'(q.size())};
         n_cmp++;
         if (ifa.status !== e_st || ifa.count !== 5'(q.size()) ||
             {ifa.head_flags, ifa.head_code} !== {m_head[9:8], m_head[7:0]}) begin
            n_bad++;
            $display("FAIL random[%0d]: got st=%h cnt=%0d head=%h/%b want st=%h cnt=%0d head=%h/%b",
                     c, ifa.status, ifa.count, ifa.head_code, ifa.head_flags,
                     e_st, q.size(), m_head[7:0], m_head[9:8]);
         end
      end
      pop = 1'b0; clr_ovf = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_pop_push();
      test_drop_release();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
